// File: rtl/aes_pkg.sv
// Shared AES tables, FSM encoding and GF(2^8) helpers for the AES-128 decrypter.
// Latency: none (pure definitions).
// Backpressure: not applicable.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} fsm_t;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry 0 is unused; round constants are indexed 1..10.
  localparam logic [0:87] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    return SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sub_byte(input logic [7:0] x);
    return INV_SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon_byte(input logic [3:0] i);
    if (i > 4'd10) return 8'h00;
    return RCON[{i, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
// Latency: combinational.
// Backpressure: none; the caller registers the result.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [0:127] state,
  input  logic [0:127] round_key,
  input  logic         last,
  output logic [0:127] next_state
);

  logic [0:127] ark;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // Row r of column c comes from column (c - r) mod 4: rows rotate right by their index.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign ark[8*(4*c+r) +: 8] =
        inv_sub_byte(state[8*(4*((c+4-r)%4)+r) +: 8]) ^ round_key[8*(4*c+r) +: 8];
    end
    assign next_state[32*c +: 32] = last ? ark[32*c +: 32] : inv_mix_col(ark[32*c +: 32]);
  end

endmodule

// File: rtl/aes_decrypter.sv
// Iterative AES-128 decrypter: expands key forward to key_10, then walks it back round by round.
// Latency: out_valid rises 20 edges after the accept edge; one job every 22 cycles at best.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no queuing.
module aes_decrypter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] cipher_data,
  input  logic [0:127] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] clear_data
);

  fsm_t         fsm;
  logic [3:0]   cnt;
  logic [0:127] key_q;
  logic [0:127] data_q;
  logic [0:127] key_fwd;
  logic [0:127] key_inv;
  logic [0:127] round_out;

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0]), sub_byte(w[31:24])};
  endfunction

  function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one schedule step: later words recover by pairwise XOR, then word 0 needs the new word 3.
  function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0] ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  assign key_fwd  = fwd_step(key_q, rcon_byte(cnt));
  assign key_inv  = inv_step(key_q, rcon_byte(cnt + 4'd1));
  assign in_ready = (fsm == IDLE);

  aes_inv_round u_inv_round (
    .state      (data_q),
    .round_key  (key_inv),
    .last       (cnt == 4'd0),
    .next_state (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      cnt        <= 4'd0;
      key_q      <= '0;
      data_q     <= '0;
      clear_data <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            key_q  <= key;
            data_q <= cipher_data;
            cnt    <= 4'd1;
            fsm    <= EXPAND;
          end
        end
        EXPAND: begin
          key_q <= key_fwd;
          if (cnt == 4'd10) begin
            data_q <= data_q ^ key_fwd;
            cnt    <= 4'd9;
            fsm    <= ROUND;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ROUND: begin
          key_q  <= key_inv;
          data_q <= round_out;
          if (cnt == 4'd0) begin
            clear_data <= round_out;
            out_valid  <= 1'b1;
            fsm        <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypter.sv
// Directed bench for aes_decrypter: known-answer vectors, latency, backpressure, hold-off, reset abort.
module tb_aes_decrypter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] cipher_data;
  logic [0:127] key;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] clear_data;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C_E  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] P_E  = 128'h6bc1bee22e409f96e93d7e117393172a;

  always #5 clk = ~clk;

  aes_decrypter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cipher_data (cipher_data),
    .key         (key),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .clear_data  (clear_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a job and returns the edge number on which it was accepted.
  task automatic start_job(input string tag, input logic [127:0] k, input logic [127:0] c,
                           input bit keep_valid, output int acc_edge);
    int n;
    key         = k;
    cipher_data = c;
    in_valid    = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_rdy"}, {127'b0, in_ready}, 128'd1);
    step();
    acc_edge = edges;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int acc_edge, input logic [127:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 128'(edges - acc_edge), 128'd20);
    chk({tag, "_pt"}, clear_data, exp);
  endtask

  initial begin
    int acc;
    int acc_prev;
    logic [127:0] held;
    logic [127:0] bk [3];
    logic [127:0] bc [3];
    logic [127:0] bp [3];

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    key         = '0;
    cipher_data = '0;

    // Reset state, before any clock edge.
    #2;
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_clear_data", clear_data, 128'd0);
    #10 rst_n = 1'b1;
    step();
    chk("rst_in_ready", {127'b0, in_ready}, 128'd1);

    // FIPS-197 C.1 with 20-edge latency and one-cycle release.
    start_job("c1", K_C1, C_C1, 1'b0, acc);
    step();
    chk("c1_busy_in_ready", {127'b0, in_ready}, 128'd0);
    wait_out("c1", acc, P_C1);
    chk("c1_done_in_ready", {127'b0, in_ready}, 128'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("c1_rel_out_valid", {127'b0, out_valid}, 128'd0);
    chk("c1_rel_in_ready", {127'b0, in_ready}, 128'd1);

    // FIPS-197 App. B under 7 cycles of backpressure.
    start_job("appb", K_B, C_B, 1'b0, acc);
    wait_out("appb", acc, P_B);
    held = clear_data;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("bp_out_valid", {127'b0, out_valid}, 128'd1);
      chk("bp_in_ready", {127'b0, in_ready}, 128'd0);
      chk("bp_stable", clear_data, held);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_rel_out_valid", {127'b0, out_valid}, 128'd0);
    chk("bp_rel_in_ready", {127'b0, in_ready}, 128'd1);

    // Inputs disturbed mid-ROUND must not affect the captured job or start another.
    start_job("hold", K_C1, C_C1, 1'b0, acc);
    repeat (13) step();
    key         = 128'hffffffffffffffffffffffffffffffff;
    cipher_data = 128'h0123456789abcdef0123456789abcdef;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out("hold", acc, P_C1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (3) step();
    chk("hold_no_second_valid", {127'b0, out_valid}, 128'd0);
    chk("hold_no_second_rdy", {127'b0, in_ready}, 128'd1);

    // Reset at cycle 12 of a job clears outputs asynchronously; next job is clean.
    start_job("abort", K_C1, C_C1, 1'b0, acc);
    repeat (12) step();
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {127'b0, out_valid}, 128'd0);
    chk("abort_clear_data", clear_data, 128'd0);
    #2 rst_n = 1'b1;
    step();
    chk("abort_in_ready", {127'b0, in_ready}, 128'd1);
    start_job("post_abort", K_B, C_B, 1'b0, acc);
    wait_out("post_abort", acc, P_B);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Back-to-back with in_valid and out_ready held high.
    bk[0] = K_C1; bc[0] = C_C1; bp[0] = P_C1;
    bk[1] = '0;   bc[1] = C_Z;  bp[1] = '0;
    bk[2] = K_B;  bc[2] = C_E;  bp[2] = P_E;
    out_ready = 1'b1;
    acc_prev  = 0;
    for (int j = 0; j < 3; j++) begin
      start_job("b2b", bk[j], bc[j], 1'b1, acc);
      if (j > 0) chk("b2b_period", 128'(acc - acc_prev), 128'd22);
      acc_prev = acc;
      wait_out("b2b", acc, bp[j]);
    end
    in_valid  = 1'b0;
    step();
    out_ready = 1'b0;
    step();
    chk("b2b_end_out_valid", {127'b0, out_valid}, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_decrypter.md
AES_DECRYPTER -- requirements
Module: aes_decrypter

Interface
REQ-001 The block SHALL have no parameters; AES-128 only, 10 rounds fixed.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  cipher_data and key are valid.
REQ-005 in_ready  output  1  block can accept a new job.
REQ-006 cipher_data  input  [0:127]  ciphertext; bit 0 is the MSB of byte 0, byte 0 is state[row0,col0].
REQ-007 key  input  [0:127]  AES-128 cipher key, same bit/byte order.
REQ-008 out_valid  output  1  clear_data is valid.
REQ-009 out_ready  input  1  consumer accepts clear_data.
REQ-010 clear_data  output  [0:127]  recovered plaintext, same bit/byte order.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, EXPAND, ROUND and DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; accept occurs on a clock edge with in_valid=1 and in_ready=1.
REQ-013 On accept, the block SHALL register cipher_data and key, set round counter cnt=1 and go to EXPAND; later changes on the inputs SHALL be ignored.
REQ-014 EXPAND: each cycle SHALL compute round key cnt from round key cnt-1 per the FIPS-197 schedule (RotWord, SubWord, Rcon[cnt]), with cnt running 1..10.
REQ-015 On the edge that produces key_10, the state register SHALL load cipher ^ key_10, cnt SHALL load 9, and the FSM SHALL go to ROUND.
REQ-016 The round key SHALL be walked backwards on the fly: key_{r} = inverse schedule step of key_{r+1}, so no 11-entry key storage is allowed.
REQ-017 ROUND, r = cnt from 9 down to 0: state SHALL become InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), key_r)); InvMixColumns SHALL be omitted when r=0.
REQ-018 After r=0 the FSM SHALL go to DONE, and clear_data SHALL hold the result.
REQ-019 Latency: out_valid SHALL rise exactly 20 clock edges after the accept edge.
REQ-020 DONE: out_valid=1, and clear_data SHALL remain stable until an edge with out_ready=1.
REQ-021 DONE with out_ready=1 SHALL go to IDLE on that edge, and out_valid SHALL drop to 0 on that edge.
REQ-022 in_ready SHALL rise the cycle after DONE exits; there is no same-cycle accept-on-release.
REQ-023 Outside DONE, out_valid SHALL be 0; out_ready SHALL be ignored in IDLE, EXPAND and ROUND.
REQ-024 in_valid SHALL be ignored in EXPAND, ROUND and DONE; there is no queuing.
REQ-025 All GF(2^8) arithmetic SHALL use modulus x^8+x^4+x^3+x+1; all XORs are 128-bit and carry-free.

Reset
REQ-026 rst_n=0 SHALL force state=IDLE, cnt=0, state/key/data registers=0, out_valid=0 and clear_data=0 immediately, without waiting for clk.
REQ-027 Reset asserted mid-EXPAND or mid-ROUND SHALL abort the job with no output; the first accept after release SHALL start a fresh job.
REQ-028 in_ready SHALL be 1 on the first edge after rst_n deasserts.

Structure
REQ-029 Shared package aes_pkg SHALL hold the SBOX, INV_SBOX and RCON tables, the FSM state encoding, and the xtime/gf_mul functions.
REQ-030 One combinational sub-module aes_inv_round (inputs: state, round_key, last; output: next_state) SHALL implement REQ-017.
REQ-031 Key-schedule forward and inverse steps SHALL live in the top module.
REQ-032 Target size is 120-400 RTL lines, including aes_inv_round.

Verification
REQ-033 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> clear_data 00112233445566778899aabbccddeeff, with out_valid exactly 20 edges after accept.
REQ-034 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> clear_data 3243f6a8885a308d313198a2e0370734.
REQ-035 Backpressure: hold out_ready=0 for 7 cycles after out_valid -> clear_data stable and in_ready=0 throughout; on release, in_ready=1 the next cycle.
REQ-036 Input hold-off: change key and cipher_data and pulse in_valid during ROUND -> result still matches the captured C.1 values, and no second job starts.
REQ-037 Reset abort: assert rst_n=0 at cycle 12 of a job -> out_valid=0 and clear_data=0 at once; the next job (App. B) completes correctly.
REQ-038 Back-to-back: in_valid held at 1 and out_ready held at 1 for 3 jobs -> one accept per 22 cycles, all three results correct.
